// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle core control FSM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ctrl_pkg;

    // Controller states; one per datapath step of the multicycle core.
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        ILLEGAL = 4'd10
    } ctrl_state_t;

    // ALU B operand select encodings.
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select encodings.
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Instruction-class encodings of Op (instruction bits [27:26]).
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Full control word driven onto the datapath each cycle.
    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       illegal_op;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Maps the controller state (plus mem_ready in FETCH) to the datapath control word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; mem_ready only qualifies the IR/PC load in FETCH.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  ctrl_state_t state,
    input  logic        mem_ready,
    output ctrl_word_t  ctrl
);

    // Moore decode of the state; anything not set for a state stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
                // Load IR and bump PC only on the cycle the fetch completes.
                ctrl.ir_write   = mem_ready;
                ctrl.next_pc    = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
            end
            MEMADR: begin
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = 1'b0;
            end
            MEMRD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
            end
            MEMWR: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_w      = 1'b1;
            end
            EXECR: begin
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = 1'b1;
            end
            EXECI: begin
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = 1'b1;
            end
            ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALU;
                ctrl.branch     = 1'b1;
            end
            ILLEGAL: begin
                ctrl.illegal_op = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main multicycle core controller: sequences fetch/decode/execute/mem/writeback, counts retires.
// Latency: ALU 4, branch 3, load 5, store 4 cycles at zero wait states.
// Backpressure: mem_ready low stalls FETCH, MEMRD and MEMWR one cycle each, no timeout.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instret
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic        retire;
    logic        run_q;
    ctrl_word_t  ctrl;

    // Funct[4:1] carry ALU function bits consumed by the ALU decoder, not here.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    // Reset release is retimed to clk: the FSM starts on the first edge after release,
    // and enables stay low until then; assertion takes effect immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // State register; held in FETCH until the retimed reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else if (run_q) begin
            state_q <= state_d;
        end
    end

    // Next-state and retire decision for the current state.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (Op)
                    OP_MEM:  state_d = MEMADR;
                    OP_DP:   state_d = Funct[5] ? EXECI : EXECR;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = ILLEGAL;
                endcase
            end
            MEMADR: begin
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            MEMWR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXECR, EXECI: begin
                state_d = ALUWB;
            end
            ALUWB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            BRANCH: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            ILLEGAL: begin
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret <= '0;
        end else if (run_q && retire) begin
            instret <= instret + CNT_W'(1);
        end
    end

    ctrl_out_decode u_out_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Mux selects pass straight through (FETCH values in reset); strobes are
    // held low until the FSM is running so nothing writes during reset.
    always_comb begin
        AdrSrc     = ctrl.adr_src;
        ALUSrcA    = ctrl.alu_src_a;
        ALUSrcB    = ctrl.alu_src_b;
        ResultSrc  = ctrl.result_src;
        ALUOp      = ctrl.alu_op;
        IRWrite    = ctrl.ir_write   & run_q;
        NextPC     = ctrl.next_pc    & run_q;
        RegW       = ctrl.reg_w      & run_q;
        MemW       = ctrl.mem_w      & run_q;
        Branch     = ctrl.branch     & run_q;
        illegal_op = ctrl.illegal_op & run_q;
    end

endmodule
